atlantic_param_fifo: RTL



---
 rtl/atlantic_param_fifo.sv | 137 +++++++++++++
 1 files changed

// File: rtl/atlantic_param_fifo.sv
// Show-ahead valid/ready FIFO with registered flags and sync flush; word written at edge k is visible after edge k+1.
// in_ready drops only when full or flushing; reads stream without bubbles. Packet sideband: ATLANTIC_FIFO_PKT_EN.
module atlantic_param_fifo #(
    parameter int DATA_WIDTH          = 36,
    parameter int DEPTH               = 8,
    parameter int ALMOST_FULL_THRESH  = DEPTH - 2,
    parameter int ALMOST_EMPTY_THRESH = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    input  logic [DATA_WIDTH-1:0]     in_data,
    output logic                      in_ready,
    output logic                      out_valid,
    output logic [DATA_WIDTH-1:0]     out_data,
    input  logic                      out_ready,
`ifdef ATLANTIC_FIFO_PKT_EN
    input  logic                      in_sop,
    input  logic                      in_eop,
    output logic                      out_sop,
    output logic                      out_eop,
    output logic [$clog2(DEPTH):0]    pkt_count,
`endif
    output logic [$clog2(DEPTH):0]    fill_level,
    output logic                      almost_full,
    output logic                      almost_empty
);

    localparam int AW = $clog2(DEPTH);
`ifdef ATLANTIC_FIFO_PKT_EN
    localparam int MW = DATA_WIDTH + 2;
`else
    localparam int MW = DATA_WIDTH;
`endif
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_LVL   = (AW+1)'(ALMOST_FULL_THRESH);
    localparam logic [AW:0] AE_LVL   = (AW+1)'(ALMOST_EMPTY_THRESH);

    logic [MW-1:0] mem_q [DEPTH];
    logic [MW-1:0] wr_word;
    logic [MW-1:0] out_word_q;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   fill_q, fill_d;
    logic [AW:0]   avail;
    logic          out_valid_q, out_valid_d;
    logic          almost_full_q, almost_empty_q;
    logic          wr, rd;

    assign in_ready = (fill_q != FULL_LVL) && !flush;
    assign wr       = in_valid && in_ready;
    assign rd       = out_valid_q && out_ready;

`ifdef ATLANTIC_FIFO_PKT_EN
    assign wr_word = {in_sop, in_eop, in_data};
`else
    assign wr_word = in_data;
`endif

    always_comb begin
        wr_ptr_d = wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
        fill_d   = fill_q;
        if (wr && !rd) begin
            fill_d = fill_q + 1'b1;
        end else if (rd && !wr) begin
            fill_d = fill_q - 1'b1;
        end
        // Only words already in memory before this edge can be presented next;
        // a word written this edge shows up one edge later.
        avail       = rd ? fill_q - 1'b1 : fill_q;
        out_valid_d = (avail != '0);
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            fill_q         <= '0;
            out_valid_q    <= 1'b0;
            almost_full_q  <= (AF_LVL == '0);
            almost_empty_q <= 1'b1;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            fill_q         <= fill_d;
            out_valid_q    <= out_valid_d;
            almost_full_q  <= (fill_d >= AF_LVL);
            almost_empty_q <= (fill_d <= AE_LVL);
        end
    end

    // Storage and the show-ahead register carry no reset; out_valid qualifies them.
    always_ff @(posedge clk) begin
        if (wr && !reset) begin
            mem_q[wr_ptr_q] <= wr_word;
        end
        out_word_q <= mem_q[rd_ptr_d];
    end

`ifdef ATLANTIC_FIFO_PKT_EN
    logic [AW:0] pkt_q, pkt_d;
    logic        eop_in, eop_out;

    assign eop_in  = wr && in_eop;
    assign eop_out = rd && out_word_q[DATA_WIDTH];

    always_comb begin
        pkt_d = pkt_q;
        if (eop_in && !eop_out) begin
            pkt_d = pkt_q + 1'b1;
        end else if (eop_out && !eop_in) begin
            pkt_d = pkt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            pkt_q <= '0;
        end else begin
            pkt_q <= pkt_d;
        end
    end

    assign out_sop   = out_word_q[DATA_WIDTH+1];
    assign out_eop   = out_word_q[DATA_WIDTH];
    assign pkt_count = pkt_q;
`endif

    assign out_valid    = out_valid_q;
    assign out_data     = out_word_q[DATA_WIDTH-1:0];
    assign fill_level   = fill_q;
    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;

endmodule
